multi_debounce: RTL and testbench
=================================

# multi_debounce

Parametrised N-channel push-button debouncer, the successor to the single-channel transmit debouncer. Each channel synchronises a raw button into `clk`, integrates it with a saturating up/down counter, and produces a hysteretic debounced level, one-cycle rise/fall pulses, and a sticky request. A consumer clears the request with a per-channel `clr` (e.g. UART transmit-done). After a clear, the channel stays locked until the button is released, so a held button cannot retrigger. It sits between board buttons and the UART/control logic.

## Interface
- `N`, 4, number of independent channels
- `CNT_W`, 8, integrator counter width; saturation value MAX = 2^CNT_W-1
- `ON_TH`, 20, counter value at or above which level asserts
- `OFF_TH`, 4, counter value at or below which level deasserts; legal only if 0 <= OFF_TH < ON_TH <= MAX
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — synchronous, active-high reset
- `btn` in N — raw asynchronous button inputs
- `clr` in N — per-channel clear/acknowledge, synchronous to `clk`
- `level` out N — debounced level, registered
- `rise` out N — one-cycle pulse on each level 0->1, registered
- `fall` out N — one-cycle pulse on each level 1->0 caused by integration, registered
- `req` out N — sticky request, set by rise, cleared by clr

## Operation
- Per channel, each stage is independent; no cross-channel interaction.
- Sync: ff1 <= btn; s <= ff1. Reset value 0.
- Priority per cycle, highest first: rst, clr, lock, integrate.
- rst: ff1, s, cnt, level, rise, fall, req, and lock all go to 0.
- clr[i]=1:
  - cnt <= 0, level <= 0, req <= 0, lock <= 1, rise <= 0.
  - fall <= 0; a forced drop never produces a fall pulse.
- lock=1 and clr=0:
  - cnt is held at 0; level, rise, fall, and req are held at 0.
  - lock <= 0 in the first cycle s=0 is sampled.
  - Integration resumes the following cycle.
- Integrate, where lock=0 and clr=0:
  - s=1: cnt <= cnt+1 if cnt != MAX, else unchanged (saturate).
  - s=0: cnt <= cnt-1 if cnt != 0, else unchanged.
- Level uses the registered (pre-update) cnt:
  - set condition: cnt >= ON_TH.
  - clear condition: cnt <= OFF_TH.
  - Otherwise level holds.
- Pulses:
  - rise <= ~level & set condition.
  - fall <= level & clear condition.
  - Both are 0 in every other cycle.
- req: req <= 1 in the same cycle rise is registered; holds until clr or rst.
- No arithmetic wrap is possible. The counter never leaves [0, MAX].

## Timing
- btn stable high from before edge 1 (lock=0, cnt=0):
  - s=1 after edge 2; cnt=m after edge 2+m.
  - level, rise, and req assert after edge 3+ON_TH; rise drops after edge 4+ON_TH.
- Release when the counter holds value c (c > OFF_TH), btn low before edge r+1:
  - s=0 after edge r+2.
  - level falls and the fall pulse occurs after edge r+3+(c-OFF_TH).
- clr takes effect at the edge it is sampled; all outputs for that channel read 0 in the next cycle.
- With btn low, the lock releases 3 edges after btn falls (2 sync edges plus 1).
- Glitches shorter than the counter margin are absorbed: net up-count must reach ON_TH.
- Between OFF_TH and ON_TH, level holds in either direction (hysteresis).
- clr and the rise condition in the same cycle: clr wins; no rise and no req.
- rst mid-press: everything returns to 0 and the lock is not set. A still-held button re-integrates from cnt=0 after rst deasserts.

## Test plan
- N=2, CNT_W=3, ON_TH=4, OFF_TH=1; btn[0]=1 held 12 cycles from reset.
  - Expect level[0]=1 and req[0]=1 after edge 7, and rise[0] high for exactly one cycle.
  - Channel 1 outputs stay 0 throughout.
- Same config, saturation: btn[0] held 20 cycles, then released.
  - cnt stays at 7 while held.
  - fall[0] pulses once, and level drops after edge r+9 (7-1 decrements plus 3).
- Hysteresis/glitch: drive btn[0] in the pattern 1,1,1,0,1,1,0,0 repeatedly.
  - Level asserts only once the net count reaches 4.
  - After assertion, it never drops while the count stays at 2 or above.
- Lockout: assert level[0] with btn held, pulse clr[0] for 1 cycle, keep btn held 30 cycles.
  - Expect level, req, and rise at 0, and no fall pulse.
  - Release btn for 3 cycles, then press again: a normal rise occurs at edge 7 relative to the new press.
- Simultaneous events: clr[1] in the same cycle as the rise condition on channel 1, while channel 0 rises that same cycle.
  - Channel 1 shows no rise and no req.
  - Channel 0 shows rise and req.
- Reset mid-operation: rst for 1 cycle while cnt=3 and btn is held.
  - All outputs read 0 next cycle.
  - level reasserts 7 edges after rst deasserts, with no lockout.

Source files
------------

// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : multi_debounce
//  Purpose  : N-channel push-button debouncer. Each channel synchronises a raw
//             button, integrates it with a saturating up/down counter and
//             produces a hysteretic level, one-cycle rise/fall pulses and a
//             sticky request. A per-channel clear drops the request and locks
//             the channel until the button has been released.
//  Ports    : clk      - single clock, all logic on posedge
//             rst      - synchronous active-high reset
//             btn_i    - raw asynchronous button inputs [N-1:0]
//             clr_i    - per-channel clear/acknowledge [N-1:0]
//             level_o  - debounced level (registered)
//             rise_o   - one-cycle pulse on level 0->1 (registered)
//             fall_o   - one-cycle pulse on integrated level 1->0 (registered)
//             req_o    - sticky request, set by rise, cleared by clr_i
//  Revision : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int N      = 4,
  parameter int CNT_W  = 8,
  parameter int ON_TH  = 20,
  parameter int OFF_TH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  input  logic [N-1:0] clr_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] req_o
);

  localparam logic [CNT_W-1:0] c_max    = '1;
  localparam logic [CNT_W-1:0] c_on_th  = CNT_W'(ON_TH);
  localparam logic [CNT_W-1:0] c_off_th = CNT_W'(OFF_TH);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             ff1_q;
    logic             s_q;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             req_q,   req_d;
    logic             lock_q,  lock_d;
    logic             w_set;
    logic             w_drop;

    // Thresholds look at the pre-update counter, so level lags cnt by a cycle.
    assign w_set  = (cnt_q >= c_on_th);
    assign w_drop = (cnt_q <= c_off_th);

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      req_d   = req_q;
      lock_d  = lock_q;
      if (clr_i[i]) begin
        // Forced drop: no fall pulse, and the channel waits for a release.
        cnt_d   = '0;
        level_d = 1'b0;
        req_d   = 1'b0;
        lock_d  = 1'b1;
      end else if (lock_q) begin
        cnt_d   = '0;
        level_d = 1'b0;
        req_d   = 1'b0;
        if (!s_q) begin
          lock_d = 1'b0;
        end
      end else begin
        if (s_q) begin
          if (cnt_q != c_max) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        rise_d = ~level_q & w_set;
        fall_d = level_q & w_drop;
        // Between the thresholds the level simply holds (hysteresis).
        if (w_set) begin
          level_d = 1'b1;
        end else if (w_drop) begin
          level_d = 1'b0;
        end
        req_d = req_q | rise_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ff1_q   <= 1'b0;
        s_q     <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        req_q   <= 1'b0;
        lock_q  <= 1'b0;
      end else begin
        ff1_q   <= btn_i[i];
        s_q     <= ff1_q;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        req_q   <= req_d;
        lock_q  <= lock_d;
      end
    end

    assign level_o[i] = level_q;
    assign rise_o[i]  = rise_q;
    assign fall_o[i]  = fall_q;
    assign req_o[i]   = req_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_debounce
//  Purpose  : Self-checking bench for multi_debounce (N=2, CNT_W=3, ON_TH=4,
//             OFF_TH=1). Directed scenarios with timing expectations plus a
//             randomized run against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  localparam int N      = 2;
  localparam int CNT_W  = 3;
  localparam int ON_TH  = 4;
  localparam int OFF_TH = 1;
  localparam int MAX    = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] clr = '0;
  logic [N-1:0] level, rise, fall, req;

  int n_tests = 0;
  int n_fail  = 0;

  multi_debounce #(
    .N(N), .CNT_W(CNT_W), .ON_TH(ON_TH), .OFF_TH(OFF_TH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn),
    .clr_i  (clr),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall),
    .req_o  (req)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integers, per channel) ----------
  bit m_p1[N], m_s[N], m_lvl[N], m_rise[N], m_fall[N], m_req[N], m_lock[N];
  int m_cnt[N];

  function automatic void model_step();
    for (int ch = 0; ch < N; ch++) begin
      if (rst) begin
        m_p1[ch] = 0; m_s[ch] = 0; m_cnt[ch] = 0; m_lvl[ch] = 0;
        m_rise[ch] = 0; m_fall[ch] = 0; m_req[ch] = 0; m_lock[ch] = 0;
      end else begin
        bit s_old;
        int c;
        s_old     = m_s[ch];
        c         = m_cnt[ch];
        m_s[ch]   = m_p1[ch];
        m_p1[ch]  = btn[ch];
        m_rise[ch] = 0;
        m_fall[ch] = 0;
        if (clr[ch]) begin
          m_cnt[ch] = 0; m_lvl[ch] = 0; m_req[ch] = 0; m_lock[ch] = 1;
        end else if (m_lock[ch]) begin
          m_cnt[ch] = 0; m_lvl[ch] = 0; m_req[ch] = 0;
          if (!s_old) m_lock[ch] = 0;
        end else begin
          m_rise[ch] = !m_lvl[ch] && (c >= ON_TH);
          m_fall[ch] = m_lvl[ch] && (c <= OFF_TH);
          if (c >= ON_TH) m_lvl[ch] = 1;
          else if (c <= OFF_TH) m_lvl[ch] = 0;
          if (m_rise[ch]) m_req[ch] = 1;
          if (s_old) m_cnt[ch] = (c + 1 > MAX) ? MAX : c + 1;
          else       m_cnt[ch] = (c - 1 < 0) ? 0 : c - 1;
        end
      end
    end
  endfunction

  // Packed as {req, fall, rise, level} to match the DUT concatenation.
  function automatic logic [4*N-1:0] model_out();
    logic [4*N-1:0] v;
    v = '0;
    for (int ch = 0; ch < N; ch++) begin
      v[ch]       = m_lvl[ch];
      v[N + ch]   = m_rise[ch];
      v[2*N + ch] = m_fall[ch];
      v[3*N + ch] = m_req[ch];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0; clr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst = 1'b1; btn = '1; clr = '0;
    tick(); tick();
    n_tests++;
    if ({req, fall, rise, level} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset got %b exp %b", {req, fall, rise, level}, 8'h00);
    end
    rst = 1'b0; btn = '0;
  endtask

  task automatic test_press();
    logic [7:0] exp;
    do_reset();
    btn = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = '0;
      exp[0] = (e >= 7); exp[2] = (e == 7); exp[6] = (e >= 7);
      n_tests++;
      if ({req, fall, rise, level} !== exp) begin
        n_fail++;
        $display("FAIL press e=%0d got %b exp %b", e, {req, fall, rise, level}, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp;
    do_reset();
    btn = 2'b01;
    for (int e = 1; e <= 20; e++) tick();
    btn = 2'b00;
    for (int e = 21; e <= 35; e++) begin
      tick();
      exp = '0;
      exp[0] = (e < 29); exp[4] = (e == 29); exp[6] = 1'b1;
      n_tests++;
      if ({req, fall, rise, level} !== exp) begin
        n_fail++;
        $display("FAIL saturation e=%0d got %b exp %b", e, {req, fall, rise, level}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] pat;
    bit seen;
    pat  = 8'b0011_0111;   // applied LSB first: 1,1,1,0,1,1,0,0
    seen = 0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      btn[0] = pat[k % 8];
      tick();
      n_tests++;
      if ({req, fall, rise, level} !== model_out()) begin
        n_fail++;
        $display("FAIL glitch k=%0d got %b exp %b", k, {req, fall, rise, level}, model_out());
      end
      n_tests++;
      if (seen && level[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL glitch_hold k=%0d level got %b exp 1", k, level[0]);
      end
      seen = seen | (level[0] === 1'b1);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL glitch_assert level got 0 exp 1");
    end
    btn = '0;
  endtask

  task automatic test_lockout();
    logic [7:0] exp;
    do_reset();
    btn = 2'b01;
    for (int e = 1; e <= 8; e++) tick();
    clr = 2'b01;
    tick();
    clr = 2'b00;
    n_tests++;
    if ({req, fall, rise, level} !== 8'h00) begin
      n_fail++;
      $display("FAIL lock_clr got %b exp %b", {req, fall, rise, level}, 8'h00);
    end
    for (int k = 0; k < 33; k++) begin
      if (k == 30) btn = 2'b00;
      tick();
      n_tests++;
      if ({req, fall, rise, level} !== 8'h00) begin
        n_fail++;
        $display("FAIL lock_hold k=%0d got %b exp %b", k, {req, fall, rise, level}, 8'h00);
      end
    end
    btn = 2'b01;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = '0;
      exp[0] = (e >= 7); exp[2] = (e == 7); exp[6] = (e >= 7);
      n_tests++;
      if ({req, fall, rise, level} !== exp) begin
        n_fail++;
        $display("FAIL lock_repress e=%0d got %b exp %b", e, {req, fall, rise, level}, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn = 2'b11;
    for (int e = 1; e <= 6; e++) tick();
    clr = 2'b10;
    tick();
    clr = 2'b00;
    // ch0: level, rise, req; ch1: nothing
    n_tests++;
    if ({req, fall, rise, level} !== 8'b01_00_01_01) begin
      n_fail++;
      $display("FAIL simul got %b exp %b", {req, fall, rise, level}, 8'b01_00_01_01);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if ({req, fall, rise, level} !== 8'b01_00_00_01) begin
        n_fail++;
        $display("FAIL simul_after k=%0d got %b exp %b", k, {req, fall, rise, level}, 8'b01_00_00_01);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn = 2'b01;
    for (int e = 1; e <= 5; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({req, fall, rise, level} !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid got %b exp %b", {req, fall, rise, level}, 8'h00);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_tests++;
      if (level[0] !== (e >= 7) || rise[0] !== (e == 7)) begin
        n_fail++;
        $display("FAIL rstmid_re e=%0d got lvl=%b rise=%b exp lvl=%b rise=%b",
                 e, level[0], rise[0], (e >= 7), (e == 7));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 9) == 0) btn[ch] = ~btn[ch];
        clr[ch] = ($urandom_range(0, 39) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      n_tests++;
      if ({req, fall, rise, level} !== model_out()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %b exp %b", cyc, {req, fall, rise, level}, model_out());
      end
    end
    rst = 1'b0; clr = '0; btn = '0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_saturation();
    test_glitch();
    test_lockout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
